// File: rtl/c_pkg.sv
// Shared constants, tracker state and instruction-format encoders for the
// compressed-instruction expansion stage.
package c_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // RV32I funct3 values used by the expansions
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Compressed quadrants
  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  // Compressed funct3 (inst16[15:13]) per quadrant
  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_ALU      = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_JR       = 3'b100;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  typedef enum logic {IDLE = 1'b0, HALF = 1'b1} trk_state_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/c_expander.sv
// Combinational RV32C -> RV32I expander. Illegal/reserved encodings return
// the raw halfword zero-extended, with illegal_o set.
module c_expander
  import c_pkg::*;
(
  input  logic [15:0] inst16_i,
  output logic [31:0] inst32_o,
  output logic        illegal_o
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm_ci, imm_4spn, imm_lw, imm_16sp, imm_lwsp, imm_swsp;
  logic [19:0] imm_lui;
  logic [20:0] imm_j;
  logic [12:0] imm_b;
  logic [31:0] inst_x;
  logic        ill;

  assign c    = inst16_i;
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};

  assign imm_ci   = {{6{c[12]}}, c[12], c[6:2]};
  assign imm_4spn = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign imm_16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
  assign imm_lui  = {{14{c[12]}}, c[12], c[6:2]};
  assign imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
  assign imm_j    = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign imm_b    = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  // Decode quadrant/funct3 and build the equivalent 32-bit instruction
  always_comb begin
    inst_x = NOP;
    ill    = 1'b0;
    case (c[1:0])
      Q0: begin
        case (c[15:13])
          C0_ADDI4SPN: if (imm_4spn == '0) ill = 1'b1;
                       else inst_x = enc_i(imm_4spn, 5'd2, F3_ADD, rdp, OP_IMM);
          C0_LW:       inst_x = enc_i(imm_lw, rs1p, F3_W, rdp, LOAD);
          C0_SW:       inst_x = enc_s(imm_lw, rdp, rs1p, F3_W, STORE);
          default:     ill = 1'b1;
        endcase
      end
      Q1: begin
        case (c[15:13])
          C1_ADDI: inst_x = enc_i(imm_ci, rd, F3_ADD, rd, OP_IMM);
          C1_JAL:  inst_x = enc_j(imm_j, 5'd1, JAL);
          C1_LI:   inst_x = enc_i(imm_ci, 5'd0, F3_ADD, rd, OP_IMM);
          C1_LUI: begin
            // rd=x2 selects ADDI16SP; both forms reserve a zero immediate
            if (rd == 5'd2) begin
              if (imm_16sp == '0) ill = 1'b1;
              else inst_x = enc_i(imm_16sp, 5'd2, F3_ADD, 5'd2, OP_IMM);
            end else begin
              if (imm_ci == '0) ill = 1'b1;
              else inst_x = enc_u(imm_lui, rd, LUI);
            end
          end
          C1_ALU: begin
            case (c[11:10])
              2'b00: if (c[12]) ill = 1'b1;
                     else inst_x = enc_i({7'b0000000, c[6:2]}, rs1p, F3_SR, rs1p, OP_IMM);
              2'b01: if (c[12]) ill = 1'b1;
                     else inst_x = enc_i({7'b0100000, c[6:2]}, rs1p, F3_SR, rs1p, OP_IMM);
              2'b10: inst_x = enc_i(imm_ci, rs1p, F3_AND, rs1p, OP_IMM);
              default: begin
                if (c[12]) ill = 1'b1;
                else begin
                  case (c[6:5])
                    2'b00:   inst_x = enc_r(7'b0100000, rdp, rs1p, F3_ADD, rs1p, OP);
                    2'b01:   inst_x = enc_r(7'b0000000, rdp, rs1p, F3_XOR, rs1p, OP);
                    2'b10:   inst_x = enc_r(7'b0000000, rdp, rs1p, F3_OR, rs1p, OP);
                    default: inst_x = enc_r(7'b0000000, rdp, rs1p, F3_AND, rs1p, OP);
                  endcase
                end
              end
            endcase
          end
          C1_J:    inst_x = enc_j(imm_j, 5'd0, JAL);
          C1_BEQZ: inst_x = enc_b(imm_b, 5'd0, rs1p, F3_BEQ, BRANCH);
          default: inst_x = enc_b(imm_b, 5'd0, rs1p, F3_BNE, BRANCH);
        endcase
      end
      Q2: begin
        case (c[15:13])
          C2_SLLI: if (c[12]) ill = 1'b1;
                   else inst_x = enc_i({7'b0000000, c[6:2]}, rd, F3_SLL, rd, OP_IMM);
          C2_LWSP: inst_x = enc_i(imm_lwsp, 5'd2, F3_W, rd, LOAD);
          C2_JR: begin
            if (!c[12]) begin
              if (rs2 != 5'd0)     inst_x = enc_r(7'b0, rs2, 5'd0, F3_ADD, rd, OP);
              else if (rd == 5'd0) ill = 1'b1;
              else                 inst_x = enc_i(12'h000, rd, F3_ADD, 5'd0, JALR);
            end else begin
              if (rs2 != 5'd0)     inst_x = enc_r(7'b0, rs2, rd, F3_ADD, rd, OP);
              else if (rd == 5'd0) inst_x = enc_i(12'h001, 5'd0, 3'b000, 5'd0, SYSTEM);
              else                 inst_x = enc_i(12'h000, rd, F3_ADD, 5'd1, JALR);
            end
          end
          C2_SWSP: inst_x = enc_s(imm_swsp, rs2, 5'd2, F3_W, STORE);
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  assign illegal_o = ill;
  assign inst32_o  = ill ? {16'h0000, c} : inst_x;

endmodule

// File: rtl/c_expand_stage.sv
// IF/ID stage register: expands RV32C words, tracks the realigner's
// misaligned bubble/reassembly sequence and provides the sequential PC.
module c_expand_stage
  import c_pkg::*;
#(
  parameter bit          ENABLE_C = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        misaligned_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_seq_o,
  output logic        valid_o,
  output logic        is_compressed_o,
  output logic        illegal_o
);

  trk_state_e  state_q, state_d;
  logic [31:0] base_pc_q, base_pc_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d, pc_seq_q, pc_seq_d;
  logic        valid_q, valid_d, comp_q, comp_d, ill_q, ill_d;

  logic [31:0] exp_inst;
  logic        exp_ill, c_ill, is_c;

  c_expander u_expander (
    .inst16_i  (inst_i[15:0]),
    .inst32_o  (exp_inst),
    .illegal_o (exp_ill)
  );

  assign is_c  = (inst_i[1:0] != 2'b11);
  assign c_ill = !ENABLE_C || exp_ill;

  // Tracker state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage and saved base-PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q    <= NOP;
      pc_q      <= RESET_PC;
      pc_seq_q  <= RESET_PC + 32'd4;
      valid_q   <= 1'b0;
      comp_q    <= 1'b0;
      ill_q     <= 1'b0;
      base_pc_q <= '0;
    end else begin
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      pc_seq_q  <= pc_seq_d;
      valid_q   <= valid_d;
      comp_q    <= comp_d;
      ill_q     <= ill_d;
      base_pc_q <= base_pc_d;
    end
  end

  // Next state: flush beats stall beats load; tracker moves on load only
  always_comb begin
    state_d   = state_q;
    base_pc_d = base_pc_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    pc_seq_d  = pc_seq_q;
    valid_d   = valid_q;
    comp_d    = comp_q;
    ill_d     = ill_q;
    if (flush_i) begin
      state_d  = IDLE;
      inst_d   = NOP;
      pc_d     = pc_i;
      pc_seq_d = pc_i + 32'd4;
      valid_d  = 1'b0;
      comp_d   = 1'b0;
      ill_d    = 1'b0;
    end else if (!stall_i) begin
      if (misaligned_i && state_q == IDLE) begin
        // First half of a straddling instruction: emit a bubble
        state_d   = HALF;
        base_pc_d = pc_i - 32'd2;
        inst_d    = NOP;
        pc_d      = pc_i;
        pc_seq_d  = pc_i + 32'd4;
        valid_d   = 1'b0;
        comp_d    = 1'b0;
        ill_d     = 1'b0;
      end else if (misaligned_i) begin
        state_d  = IDLE;
        inst_d   = inst_i;
        pc_d     = base_pc_q;
        pc_seq_d = base_pc_q + 32'd4;
        valid_d  = 1'b1;
        comp_d   = 1'b0;
        ill_d    = 1'b0;
      end else begin
        // Normal path; also covers an abandoned HALF sequence
        state_d = IDLE;
        pc_d    = pc_i;
        valid_d = 1'b1;
        if (is_c) begin
          inst_d   = c_ill ? {16'h0000, inst_i[15:0]} : exp_inst;
          pc_seq_d = pc_i + 32'd2;
          comp_d   = 1'b1;
          ill_d    = c_ill;
        end else begin
          inst_d   = inst_i;
          pc_seq_d = pc_i + 32'd4;
          comp_d   = 1'b0;
          ill_d    = 1'b0;
        end
      end
    end
  end

  assign inst_o          = inst_q;
  assign pc_o            = pc_q;
  assign pc_seq_o        = pc_seq_q;
  assign valid_o         = valid_q;
  assign is_compressed_o = comp_q;
  assign illegal_o       = ill_q;

endmodule

// File: tb/tb_c_expand_stage.sv
// Self-checking bench for c_expand_stage: directed vector table, hand-written
// tracker/stall/flush/reset sequences, then randomized traffic against a
// behavioural model that decodes RV32C fields arithmetically.
module tb_c_expand_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [31:0] NOPW   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_i, pc_i;
  logic        misaligned_i, stall_i, flush_i;
  logic [31:0] inst_o, pc_o, pc_seq_o;
  logic        valid_o, is_compressed_o, illegal_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_expand_stage #(.ENABLE_C(1'b1), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_i          (inst_i),
    .pc_i            (pc_i),
    .misaligned_i    (misaligned_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .pc_seq_o        (pc_seq_o),
    .valid_o         (valid_o),
    .is_compressed_o (is_compressed_o),
    .illegal_o       (illegal_o)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_inst, m_pc, m_seq, m_base;
  logic        m_valid, m_comp, m_ill, m_half, m_pc_ok;

  function automatic int sx(input int unsigned v, input int n);
    if (v >= (32'd1 << (n - 1))) return int'(v) - (1 << n);
    return int'(v);
  endfunction

  function automatic logic [31:0] t_i(input int imm, input int unsigned rs1, f3, rd, op);
    int unsigned u;
    u = imm;
    return ((u & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  function automatic logic [31:0] t_r(input int unsigned f7, rs2, rs1, f3, rd, op);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  function automatic logic [31:0] t_s(input int imm, input int unsigned rs2, rs1, f3, op);
    int unsigned u;
    u = imm;
    return (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 31) << 7) | op;
  endfunction

  function automatic logic [31:0] t_b(input int imm, input int unsigned rs1, f3);
    int unsigned u;
    u = imm;
    return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs1 << 15) | (f3 << 12)
         | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
  endfunction

  function automatic logic [31:0] t_j(input int imm, input int unsigned rd);
    int unsigned u;
    u = imm;
    return (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
         | (((u >> 12) & 255) << 12) | (rd << 7) | 32'h6f;
  endfunction

  function automatic void model_expand(input logic [15:0] c, output logic [31:0] ins, output logic ill);
    int unsigned ci, q, f3, rd, rs2, rdp, rs1p, b12, sub, fn;
    int imm;
    ci = {16'h0, c};
    q = ci & 3; f3 = (ci >> 13) & 7; rd = (ci >> 7) & 31; rs2 = (ci >> 2) & 31;
    rdp = 8 + ((ci >> 2) & 7); rs1p = 8 + ((ci >> 7) & 7); b12 = (ci >> 12) & 1;
    ill = 1'b0; ins = '0;
    case (q)
      0: case (f3)
        0: begin
          imm = int'(((ci >> 6) & 1) * 4 + ((ci >> 5) & 1) * 8 + ((ci >> 11) & 3) * 16 + ((ci >> 7) & 15) * 64);
          if (imm == 0) ill = 1'b1; else ins = t_i(imm, 2, 0, rdp, 'h13);
        end
        2, 6: begin
          imm = int'(((ci >> 6) & 1) * 4 + ((ci >> 10) & 7) * 8 + ((ci >> 5) & 1) * 64);
          if (f3 == 2) ins = t_i(imm, rs1p, 2, rdp, 'h03);
          else         ins = t_s(imm, rdp, rs1p, 2, 'h23);
        end
        default: ill = 1'b1;
      endcase
      1: begin
        imm = sx(b12 * 32 + rs2, 6);
        case (f3)
          0: ins = t_i(imm, rd, 0, rd, 'h13);
          2: ins = t_i(imm, 0, 0, rd, 'h13);
          1, 5: begin
            imm = sx(((ci >> 3) & 7) * 2 + ((ci >> 11) & 1) * 16 + ((ci >> 2) & 1) * 32 + ((ci >> 7) & 1) * 64
                   + ((ci >> 6) & 1) * 128 + ((ci >> 9) & 3) * 256 + ((ci >> 8) & 1) * 1024 + b12 * 2048, 12);
            ins = t_j(imm, (f3 == 1) ? 1 : 0);
          end
          3: begin
            if (rd == 2) begin
              imm = sx(((ci >> 6) & 1) * 16 + ((ci >> 2) & 1) * 32 + ((ci >> 5) & 1) * 64
                     + ((ci >> 3) & 3) * 128 + b12 * 512, 10);
              if (imm == 0) ill = 1'b1; else ins = t_i(imm, 2, 0, 2, 'h13);
            end else begin
              if (imm == 0) ill = 1'b1;
              else ins = ((int'(imm) & 32'hfffff) << 12) | (rd << 7) | 32'h37;
            end
          end
          4: begin
            sub = (ci >> 10) & 3;
            if (sub == 0)      begin if (b12 != 0) ill = 1'b1; else ins = t_i(int'(rs2), rs1p, 5, rs1p, 'h13); end
            else if (sub == 1) begin if (b12 != 0) ill = 1'b1; else ins = t_i(int'(1024 + rs2), rs1p, 5, rs1p, 'h13); end
            else if (sub == 2) ins = t_i(imm, rs1p, 7, rs1p, 'h13);
            else if (b12 != 0) ill = 1'b1;
            else begin
              fn = (ci >> 5) & 3;
              case (fn)
                0: ins = t_r('h20, rdp, rs1p, 0, rs1p, 'h33);
                1: ins = t_r(0, rdp, rs1p, 4, rs1p, 'h33);
                2: ins = t_r(0, rdp, rs1p, 6, rs1p, 'h33);
                default: ins = t_r(0, rdp, rs1p, 7, rs1p, 'h33);
              endcase
            end
          end
          default: begin
            imm = sx(((ci >> 3) & 3) * 2 + ((ci >> 10) & 3) * 8 + ((ci >> 2) & 1) * 32 + ((ci >> 5) & 3) * 64 + b12 * 256, 9);
            ins = t_b(imm, rs1p, (f3 == 6) ? 0 : 1);
          end
        endcase
      end
      2: case (f3)
        0: if (b12 != 0) ill = 1'b1; else ins = t_i(int'(rs2), rd, 1, rd, 'h13);
        2: ins = t_i(int'(((ci >> 4) & 7) * 4 + b12 * 32 + ((ci >> 2) & 3) * 64), 2, 2, rd, 'h03);
        4: begin
          if (b12 == 0) begin
            if (rs2 != 0)     ins = t_r(0, rs2, 0, 0, rd, 'h33);
            else if (rd == 0) ill = 1'b1;
            else              ins = t_i(0, rd, 0, 0, 'h67);
          end else begin
            if (rs2 != 0)     ins = t_r(0, rs2, rd, 0, rd, 'h33);
            else if (rd == 0) ins = 32'h0010_0073;
            else              ins = t_i(0, rd, 0, 1, 'h67);
          end
        end
        6: ins = t_s(int'(((ci >> 9) & 15) * 4 + ((ci >> 7) & 3) * 64), rs2, 2, 2, 'h23);
        default: ill = 1'b1;
      endcase
      default: ill = 1'b1;
    endcase
    if (ill) ins = {16'h0, c};
  endfunction

  function automatic void model_reset();
    m_inst = NOPW; m_pc = RST_PC; m_seq = RST_PC + 32'd4;
    m_valid = 1'b0; m_comp = 1'b0; m_ill = 1'b0; m_half = 1'b0; m_pc_ok = 1'b1;
  endfunction

  function automatic void model_step(input logic [31:0] ins, pc, input logic mis, st, fl);
    logic [31:0] e;
    logic        il;
    if (fl) begin
      m_inst = NOPW; m_valid = 1'b0; m_comp = 1'b0; m_ill = 1'b0; m_half = 1'b0;
      m_pc = pc; m_seq = pc + 32'd4; m_pc_ok = 1'b1;
    end else if (!st) begin
      if (mis && !m_half) begin
        m_inst = NOPW; m_valid = 1'b0; m_comp = 1'b0; m_ill = 1'b0;
        m_half = 1'b1; m_base = pc - 32'd2; m_pc_ok = 1'b0;
      end else if (mis) begin
        m_inst = ins; m_valid = 1'b1; m_comp = 1'b0; m_ill = 1'b0;
        m_pc = m_base; m_seq = m_base + 32'd4; m_half = 1'b0; m_pc_ok = 1'b1;
      end else begin
        m_half = 1'b0; m_valid = 1'b1; m_pc = pc; m_pc_ok = 1'b1;
        if (ins[1:0] == 2'b11) begin
          m_inst = ins; m_comp = 1'b0; m_ill = 1'b0; m_seq = pc + 32'd4;
        end else begin
          model_expand(ins[15:0], e, il);
          m_inst = e; m_comp = 1'b1; m_ill = il; m_seq = pc + 32'd2;
        end
      end
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".inst"},  inst_o, m_inst);
    chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, m_valid});
    chk({tag, ".comp"},  {31'b0, is_compressed_o}, {31'b0, m_comp});
    chk({tag, ".ill"},   {31'b0, illegal_o}, {31'b0, m_ill});
    if (m_pc_ok) begin
      chk({tag, ".pc"},  pc_o, m_pc);
      chk({tag, ".seq"}, pc_seq_o, m_seq);
    end
  endtask

  task automatic drive(input logic [31:0] ins, pc, input logic mis, st, fl);
    inst_i = ins; pc_i = pc; misaligned_i = mis; stall_i = st; flush_i = fl;
    @(posedge clk);
    model_step(ins, pc, mis, st, fl);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] e_inst;
    logic [31:0] e_seq;
    logic        e_comp;
    logic        e_ill;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h0000_4515, 32'h0000_0100, 32'h0050_0513, 32'h0000_0102, 1'b1, 1'b0}; // C.LI
    tbl[1]  = '{32'h0000_85AA, 32'h0000_0104, 32'h00A0_05B3, 32'h0000_0106, 1'b1, 1'b0}; // C.MV
    tbl[2]  = '{32'h0000_0000, 32'h0000_0108, 32'h0000_0000, 32'h0000_010A, 1'b1, 1'b1}; // zero
    tbl[3]  = '{32'h0000_0001, 32'h0000_010C, 32'h0000_0013, 32'h0000_010E, 1'b1, 1'b0}; // C.NOP
    tbl[4]  = '{32'h0000_9002, 32'h0000_0110, 32'h0010_0073, 32'h0000_0112, 1'b1, 1'b0}; // EBREAK
    tbl[5]  = '{32'h0000_8082, 32'h0000_0114, 32'h0000_8067, 32'h0000_0116, 1'b1, 1'b0}; // JR ra
    tbl[6]  = '{32'h0000_8002, 32'h0000_0118, 32'h0000_8002, 32'h0000_011A, 1'b1, 1'b1}; // JR x0
    tbl[7]  = '{32'h0000_0004, 32'h0000_011C, 32'h0000_0004, 32'h0000_011E, 1'b1, 1'b1}; // ADDI4SPN 0
    tbl[8]  = '{32'h0000_6000, 32'h0000_0120, 32'h0000_6000, 32'h0000_0122, 1'b1, 1'b1}; // FLW
    tbl[9]  = '{32'h0000_41C8, 32'h0000_0124, 32'h0045_A503, 32'h0000_0126, 1'b1, 1'b0}; // C.LW
    tbl[10] = '{32'h0000_9405, 32'h0000_0128, 32'h0000_9405, 32'h0000_012A, 1'b1, 1'b1}; // SRAI sh5
    tbl[11] = '{32'h0000_9C01, 32'h0000_012C, 32'h0000_9C01, 32'h0000_012E, 1'b1, 1'b1}; // reserved
    tbl[12] = '{32'h00A0_0593, 32'h0000_0200, 32'h00A0_0593, 32'h0000_0204, 1'b0, 1'b0}; // 32-bit
    tbl[13] = '{32'h0000_4515, 32'hFFFF_FFFE, 32'h0050_0513, 32'h0000_0000, 1'b1, 1'b0}; // pc wrap
    tbl[14] = '{32'hDEAD_4515, 32'h0000_0300, 32'h0050_0513, 32'h0000_0302, 1'b1, 1'b0}; // upper ignored
    tbl[15] = '{32'h0000_BFFD, 32'h0000_0304, 32'hFFFF_F06F, 32'h0000_0306, 1'b1, 1'b0}; // C.J -2

    inst_i = '0; pc_i = '0; misaligned_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    reset = 1'b1;
    model_reset();
    #3;
    chk("rst.inst", inst_o, NOPW);
    chk("rst.pc", pc_o, RST_PC);
    chk("rst.seq", pc_seq_o, RST_PC + 32'd4);
    chk("rst.valid", {31'b0, valid_o}, 32'd0);
    chk("rst.comp", {31'b0, is_compressed_o}, 32'd0);
    chk("rst.ill", {31'b0, illegal_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed single-cycle vectors
    for (int unsigned i = 0; i < 16; i++) begin
      drive(tbl[i].inst, tbl[i].pc, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d.inst", i), inst_o, tbl[i].e_inst);
      chk($sformatf("tbl%0d.pc", i), pc_o, tbl[i].pc);
      chk($sformatf("tbl%0d.seq", i), pc_seq_o, tbl[i].e_seq);
      chk($sformatf("tbl%0d.valid", i), {31'b0, valid_o}, 32'd1);
      chk($sformatf("tbl%0d.comp", i), {31'b0, is_compressed_o}, {31'b0, tbl[i].e_comp});
      chk($sformatf("tbl%0d.ill", i), {31'b0, illegal_o}, {31'b0, tbl[i].e_ill});
    end

    // Misaligned bubble then reassembly
    drive(32'h0000_0000, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    chk("mis1.valid", {31'b0, valid_o}, 32'd0);
    chk("mis1.inst", inst_o, NOPW);
    drive(32'h0050_0513, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    chk("mis2.valid", {31'b0, valid_o}, 32'd1);
    chk("mis2.pc", pc_o, 32'h0000_0102);
    chk("mis2.seq", pc_seq_o, 32'h0000_0106);
    chk("mis2.inst", inst_o, 32'h0050_0513);
    chk("mis2.comp", {31'b0, is_compressed_o}, 32'd0);
    // base_pc wraps below zero
    drive(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drive(32'h00A0_0593, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
    chk("miswrap.pc", pc_o, 32'hFFFF_FFFE);
    chk("miswrap.seq", pc_seq_o, 32'h0000_0002);

    // Stall holds, flush overrides stall
    drive(32'h0000_4515, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 3; k++) begin
      drive($urandom, $urandom, k[0], 1'b1, 1'b0);
      chk($sformatf("stall%0d.inst", k), inst_o, 32'h0050_0513);
      chk($sformatf("stall%0d.pc", k), pc_o, 32'h0000_0100);
      chk($sformatf("stall%0d.seq", k), pc_seq_o, 32'h0000_0102);
      chk($sformatf("stall%0d.valid", k), {31'b0, valid_o}, 32'd1);
    end
    drive(32'h0000_4515, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
    chk("flushst.valid", {31'b0, valid_o}, 32'd0);
    chk("flushst.inst", inst_o, NOPW);
    chk("flushst.pc", pc_o, 32'h0000_0200);
    chk("flushst.seq", pc_seq_o, 32'h0000_0204);
    chk("flushst.comp", {31'b0, is_compressed_o}, 32'd0);

    // Stall in HALF must not advance the tracker
    drive(32'h0000_0000, 32'h0000_0300, 1'b1, 1'b0, 1'b0);
    drive(32'h0000_0000, 32'h0000_0400, 1'b0, 1'b1, 1'b0);
    chk("halfstall.valid", {31'b0, valid_o}, 32'd0);
    drive(32'h00A0_0593, 32'h0000_0304, 1'b1, 1'b0, 1'b0);
    chk("halfstall.rvalid", {31'b0, valid_o}, 32'd1);
    chk("halfstall.pc", pc_o, 32'h0000_02FE);

    // Flush in HALF: next misaligned word is a fresh bubble
    drive(32'h0000_0000, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
    drive(32'h0000_0000, 32'h0000_0500, 1'b0, 1'b0, 1'b1);
    drive(32'h00A0_0593, 32'h0000_0504, 1'b1, 1'b0, 1'b0);
    chk("flushhalf.valid", {31'b0, valid_o}, 32'd0);
    chk("flushhalf.inst", inst_o, NOPW);
    drive(32'h00A0_0593, 32'h0000_0508, 1'b1, 1'b0, 1'b0);
    chk("flushhalf.rvalid", {31'b0, valid_o}, 32'd1);
    chk("flushhalf.pc", pc_o, 32'h0000_0502);

    // Abandoned sequence: word processed normally
    drive(32'h0000_0000, 32'h0000_0600, 1'b1, 1'b0, 1'b0);
    drive(32'h0000_4515, 32'h0000_0700, 1'b0, 1'b0, 1'b0);
    chk("aband.inst", inst_o, 32'h0050_0513);
    chk("aband.pc", pc_o, 32'h0000_0700);
    chk("aband.seq", pc_seq_o, 32'h0000_0702);
    chk("aband.comp", {31'b0, is_compressed_o}, 32'd1);

    // Asynchronous reset mid-stream while tracker is in HALF
    drive(32'h0000_4515, 32'h0000_0800, 1'b0, 1'b0, 1'b0);
    drive(32'h0000_0000, 32'h0000_0900, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst.inst", inst_o, NOPW);
    chk("arst.valid", {31'b0, valid_o}, 32'd0);
    chk("arst.pc", pc_o, RST_PC);
    chk("arst.seq", pc_seq_o, RST_PC + 32'd4);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(32'h00A0_0593, 32'h0000_0904, 1'b1, 1'b0, 1'b0);
    chk("arst.bubble", {31'b0, valid_o}, 32'd0);

    // Randomized traffic against the model
    for (int unsigned n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      logic        rm, rs, rf;
      ri = $urandom;
      if ($urandom_range(0, 3) != 0) ri[1:0] = 2'($urandom_range(0, 2));
      else                           ri[1:0] = 2'b11;
      rm = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rf = ($urandom_range(0, 15) == 0);
      drive(ri, $urandom, rm, rs, rf);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c_expand_stage.md
Name: c_expand_stage

Overview:
- Registered IF/ID stage, directly downstream of the compressed-instruction realigner.
- Accepts one fetched 32-bit word per cycle, together with its PC and the realigner's misaligned flag.
- Expands any RV32C 16-bit instruction into its RV32I equivalent and registers the result for the decoder.
- Handles stall, flush and the misaligned bubble/reassembly sequence. Also provides the sequential next-PC (PC+2 or PC+4) for link and fall-through.

Parameters:
- ENABLE_C, 1, when 0 every compressed encoding is reported illegal.
- RESET_PC, 32'h0000_0000, value of pc_o and pc_seq_o after reset.

Ports:
- clk  input  1  clock; rising edge only.
- reset  input  1  asynchronous, active-high reset.
- inst_i  input  32  fetched or realigned word; compressed when inst_i[1:0] != 2'b11, using inst_i[15:0].
- pc_i  input  32  PC accompanying inst_i.
- misaligned_i  input  1  high while the realigner is handling a word-straddling 32-bit instruction.
- stall_i  input  1  downstream hold; the stage register keeps its value.
- flush_i  input  1  branch/jump redirect; kills the stage contents.
- inst_o  output  32  expanded 32-bit instruction.
- pc_o  output  32  PC of inst_o.
- pc_seq_o  output  32  pc_o+2 if compressed, pc_o+4 otherwise.
- valid_o  output  1  inst_o is a real instruction (not a bubble).
- is_compressed_o  output  1  inst_o originated from a 16-bit encoding.
- illegal_o  output  1  illegal or reserved compressed encoding.

Behaviour:
- Reset (asynchronous): inst_o=32'h0000_0013; pc_o=RESET_PC; pc_seq_o=RESET_PC+4; valid_o, is_compressed_o, illegal_o = 0; tracker=IDLE.
- Latency: one cycle. An input sampled at edge N is visible after edge N.
- Priority is reset > flush_i > stall_i > load.
- flush_i:
  - valid_o=0, inst_o=NOP, flags cleared, tracker=IDLE.
  - pc_o and pc_seq_o take pc_i and pc_i+4.
  - Applies even when stall_i is high.
- stall_i (without flush): all outputs and the tracker hold.
- Misaligned tracker FSM, states IDLE and HALF, advancing only on load cycles:
  - IDLE & misaligned_i=1: the cycle is a bubble. valid_o=0, inst_o=NOP. Save base_pc=pc_i-2 (32-bit wrap). Go to HALF.
  - HALF & misaligned_i=1: the word is a reassembled 32-bit instruction. valid_o=1, inst_o=inst_i unmodified, pc_o=base_pc, pc_seq_o=base_pc+4, is_compressed_o=0. Go to IDLE.
  - HALF & misaligned_i=0: abandoned sequence. Go to IDLE and process the word normally.
  - IDLE & misaligned_i=0: normal path.
- Normal path:
  - If inst_i[1:0]==2'b11, pass through with is_compressed_o=0.
  - Otherwise expand inst_i[15:0] and set is_compressed_o=1, pc_seq_o=pc_i+2.
  - All outputs have valid_o=1.
- Expansion covers all RV32C integer forms:
  - ADDI4SPN, LW, SW, NOP/ADDI, JAL, LI, ADDI16SP, LUI.
  - SRLI, SRAI, ANDI, SUB, XOR, OR, AND.
  - J, BEQZ, BNEZ, SLLI, LWSP, JR, MV, EBREAK, JALR, ADD, SWSP.
  - Immediates are sign-/zero-extended exactly per the ISA.
  - Register fields rd'/rs1'/rs2' map to x8-x15.
- Illegal (illegal_o=1, valid_o=1, inst_o={16'h0, inst_i[15:0]}):
  - all-zero halfword;
  - ADDI4SPN with nzuimm=0;
  - LUI/ADDI16SP with imm=0, and LUI with rd=x2 treated as ADDI16SP;
  - shamt[5]=1;
  - JR with rs1=0;
  - FLD/FLW/FSD/FSW and their SP-relative forms;
  - reserved funct encodings;
  - any compressed word when ENABLE_C=0.
- HINT encodings (for example ADDI with rd=0) expand normally and are not illegal.
- pc arithmetic is 32-bit modulo, with no overflow flag.

Decomposition:
- Shared package c_pkg holds:
  - opcode constants (OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, SYSTEM);
  - NOP=32'h0000_0013;
  - the tracker state enum {IDLE, HALF};
  - quadrant/funct3 constants.
- One combinational sub-module, c_expander (inst16 in; inst32 and illegal out), instantiated once. The stage register, tracker FSM and PC logic stay in the top.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges -> outputs become NOP, valid_o=0 and pc_o=RESET_PC immediately, without waiting for a clock edge.
- C.LI: inst_i=32'h0000_4515, pc_i=0x100 -> next cycle inst_o=32'h0050_0513, is_compressed_o=1, pc_seq_o=0x102, valid_o=1.
- C.MV: inst_i=0x85AA -> inst_o=32'h00A0_05B3.
- Illegal: inst_i=32'h0000_0000 -> illegal_o=1, valid_o=1.
- Misaligned: cycle1 misaligned_i=1, pc_i=0x104 -> valid_o=0. Cycle2 misaligned_i=1, inst_i=32'h0050_0513 -> valid_o=1, pc_o=0x102, pc_seq_o=0x106, inst_o unchanged.
- Stall/flush: stall_i=1 for 3 cycles with changing inputs -> outputs constant. Then flush_i=1 with stall_i=1 -> valid_o=0, inst_o=NOP. Flush in HALF -> the next misaligned word is treated as a bubble.
